morty_wb_ram: RTL

MORTY_WB_RAM -- requirements
Module: morty_wb_ram

---
 rtl/morty_pkg.sv | 29 ++
 rtl/morty_wb_ram_array.sv | 28 ++
 rtl/morty_wb_ram.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/morty_pkg.sv
// Shared definitions for the morty Wishbone RAM slice.
// FSM encoding, bus widths and the set of legal byte-lane selects.
package morty_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [WB_SEL_W-1:0] SEL_B0 = 4'b0001;
   localparam logic [WB_SEL_W-1:0] SEL_B1 = 4'b0010;
   localparam logic [WB_SEL_W-1:0] SEL_B2 = 4'b0100;
   localparam logic [WB_SEL_W-1:0] SEL_B3 = 4'b1000;
   localparam logic [WB_SEL_W-1:0] SEL_H0 = 4'b0011;
   localparam logic [WB_SEL_W-1:0] SEL_H1 = 4'b1100;
   localparam logic [WB_SEL_W-1:0] SEL_W  = 4'b1111;

   function automatic logic sel_legal(input logic [WB_SEL_W-1:0] sel);
      return (sel == SEL_B0) || (sel == SEL_B1) ||
             (sel == SEL_B2) || (sel == SEL_B3) ||
             (sel == SEL_H0) || (sel == SEL_H1) ||
             (sel == SEL_W);
   endfunction

endpackage

// File: rtl/morty_wb_ram_array.sv
// Byte-enable RAM: synchronous write per lane, combinational read.
// Contents are deliberately not reset.
module morty_wb_ram_array
   import morty_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk_i,
   input  logic                     we,
   input  logic [WB_SEL_W-1:0]      be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WB_DATA_W-1:0]     wdata,
   output logic [WB_DATA_W-1:0]     rdata
);

   logic [WB_DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         for (int i = 0; i < WB_SEL_W; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/morty_wb_ram.sv
// Wishbone classic slave RAM with programmable wait states.
// Define MORTY_WB_RAM_ERR_CHECK_EN to answer range/sel violations with err.
module morty_wb_ram
   import morty_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [WB_SEL_W-1:0]  wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [WB_DATA_W-1:0] wbs_dat_i,
   output logic [WB_DATA_W-1:0] wbs_dat_o,
   output logic                 wbs_ack_o,
   output logic                 wbs_err_o
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [AW-1:0]        idx_q;
   logic [WB_SEL_W-1:0]  sel_q;
   logic [WB_DATA_W-1:0] dat_q;
   logic                 we_q;
   logic                 bad_q;

   logic                 idle, req, latch, go_resp, bad_in;
   logic [AW-1:0]        acc_idx;
   logic [WB_SEL_W-1:0]  acc_sel;
   logic [WB_DATA_W-1:0] acc_dat;
   logic                 acc_we, acc_bad;
   logic [WB_DATA_W-1:0] rdata;
   logic                 unused_ok;

   assign idle = (state_q == ST_IDLE);
   assign req  = wbs_cyc_i & wbs_stb_i;

`ifdef MORTY_WB_RAM_ERR_CHECK_EN
   assign bad_in = (wbs_adr_i[31:AW+2] != '0) |
                   ~sel_legal(wbs_sel_i);
`else
   assign bad_in = 1'b0;
`endif

   assign unused_ok = ^{wbs_adr_i[1:0], wbs_adr_i[31:AW+2]};

   // Zero-wait accesses reach RESP on the request edge itself,
   // so the RAM sees the live bus then and the latched copy after.
   assign acc_idx = idle ? wbs_adr_i[AW+1:2] : idx_q;
   assign acc_sel = idle ? wbs_sel_i : sel_q;
   assign acc_dat = idle ? wbs_dat_i : dat_q;
   assign acc_we  = idle ? wbs_we_i  : we_q;
   assign acc_bad = idle ? bad_in    : bad_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      go_resp = 1'b0;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (req) begin
               latch = 1'b1;
               cnt_d = WAIT_LD;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         (state_q == ST_WAIT): begin
            if (!wbs_cyc_i) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end
            end
         end
         (state_q == ST_RESP): state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         idx_q <= '0;
         sel_q <= '0;
         dat_q <= '0;
         we_q  <= 1'b0;
         bad_q <= 1'b0;
      end else if (latch) begin
         idx_q <= wbs_adr_i[AW+1:2];
         sel_q <= wbs_sel_i;
         dat_q <= wbs_dat_i;
         we_q  <= wbs_we_i;
         bad_q <= bad_in;
      end
   end

   morty_wb_ram_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i (clk_i),
      .we    (go_resp & acc_we & ~acc_bad),
      .be    (acc_sel),
      .addr  (acc_idx),
      .wdata (acc_dat),
      .rdata (rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= go_resp & ~acc_bad;
         wbs_err_o <= go_resp & acc_bad;
         if (go_resp & ~acc_we)
            wbs_dat_o <= acc_bad ? '0 : rdata;
      end
   end

endmodule
